// File: rtl/jtag_cmd_sequencer_if.sv
// Command/response bus between JTAG requesters and the sequencer.
// The master side issues commands and accepts responses; the slave side is the sequencer.
interface jtag_cmd_sequencer_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_cmd;
  logic [6*NREQ-1:0]  req_nbits;
  logic [32*NREQ-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2:0]         rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_cmd, req_nbits, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_nbits, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_cmd_sequencer.sv
// Round-robin arbitrated JTAG master: runs one TAP reset, TMS sequence or scan at a time
// on TCK/TMS/TDI and returns the captured TDO bits to the issuing requester.
module jtag_cmd_sequencer #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TCK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  jtag_cmd_sequencer_if.slave bus,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);
  localparam int unsigned CntW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TCK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StErr, StResp} state_e;

  state_e          state;
  logic [2:0]      cmd, id, ptr;
  logic [4:0]      idx, last;
  logic [31:0]     data, capture;
  logic [CntW-1:0] cnt;
  logic            rsp_valid, rsp_err;
  logic [2:0]      rsp_id;
  logic [31:0]     rsp_data;

  // Requester fields padded to 8 slots so a 3-bit index always selects in range.
  logic [7:0]  valid8;
  logic [2:0]  cmd_arr   [8];
  logic [5:0]  nbits_arr [8];
  logic [31:0] data_arr  [8];

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NREQ) begin : g_used
      assign valid8[g]    = bus.req_valid[g];
      assign cmd_arr[g]   = bus.req_cmd[3*g +: 3];
      assign nbits_arr[g] = bus.req_nbits[6*g +: 6];
      assign data_arr[g]  = bus.req_data[32*g +: 32];
    end else begin : g_unused
      assign valid8[g]    = 1'b0;
      assign cmd_arr[g]   = 3'd0;
      assign nbits_arr[g] = 6'd0;
      assign data_arr[g]  = 32'd0;
    end
  end

  logic       gnt_found, gnt_en;
  logic [2:0] gnt_idx, cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 3'd0;
    cand      = 3'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 3'((32'(ptr) + k) % NREQ);
      if (!gnt_found && valid8[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_en = rst_n && (state == StIdle) && enable && gnt_found;

  for (genvar g = 0; g < NREQ; g++) begin : g_ready
    assign bus.req_ready[g] = gnt_en && (gnt_idx == 3'(g));
  end

  // {tms, tdi} for bit i of a command whose final bit index is l.
  function automatic logic [1:0] bit_pins(logic [2:0] c, logic [4:0] i, logic [4:0] l,
                                          logic [31:0] d);
    case (c)
      3'd0:    return {i != 5'd5, 1'b0};
      3'd1:    return {d[i], 1'b0};
      3'd2:    return {1'b0, d[i]};
      3'd3:    return {i == l, d[i]};
      default: return 2'b00;
    endcase
  endfunction

  logic [2:0]  sel_cmd;
  logic [4:0]  sel_last;
  logic [31:0] sel_data;
  logic [1:0]  acc_pins, nxt_pins;

  // nbits of 0 wraps to a last index of 31, i.e. a 32-bit command.
  assign sel_cmd  = cmd_arr[gnt_idx];
  assign sel_data = data_arr[gnt_idx];
  assign sel_last = (sel_cmd == 3'd0) ? 5'd5 : 5'(nbits_arr[gnt_idx] - 6'd1);
  assign acc_pins = bit_pins(sel_cmd, 5'd0, sel_last, sel_data);
  assign nxt_pins = bit_pins(cmd, idx + 5'd1, last, data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cmd       <= 3'd0;
      id        <= 3'd0;
      ptr       <= 3'd0;
      idx       <= 5'd0;
      last      <= 5'd0;
      data      <= 32'd0;
      capture   <= 32'd0;
      cnt       <= '0;
      tck       <= 1'b0;
      tms       <= 1'b0;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_id    <= 3'd0;
      rsp_data  <= 32'd0;
    end else begin
      case (state)
        StIdle: begin
          if (gnt_en) begin
            ptr     <= (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
            cmd     <= sel_cmd;
            last    <= sel_last;
            data    <= sel_data;
            id      <= gnt_idx;
            idx     <= 5'd0;
            cnt     <= '0;
            capture <= 32'd0;
            if (sel_cmd[2]) begin
              state <= StErr;
            end else begin
              state      <= StShiftLo;
              {tms, tdi} <= acc_pins;
            end
          end
        end
        StShiftLo: begin
          if (cnt == CntLast) begin
            cnt          <= '0;
            tck          <= 1'b1;
            capture[idx] <= tdo;
            state        <= StShiftHi;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StShiftHi: begin
          if (cnt == CntLast) begin
            cnt <= '0;
            tck <= 1'b0;
            if (idx != last) begin
              idx        <= idx + 5'd1;
              {tms, tdi} <= nxt_pins;
              state      <= StShiftLo;
            end else begin
              tms       <= 1'b0;
              tdi       <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= capture;
              rsp_id    <= id;
              state     <= StResp;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StErr: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_data  <= 32'd0;
          rsp_id    <= id;
          state     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy         = (state != StIdle);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_data  = rsp_data;
endmodule

// File: doc/jtag_cmd_sequencer.md
Name: jtag_cmd_sequencer

Overview:
- Synthesizable JTAG master. Replaces the behavioural VPI-driven TAP driver for on-chip and FPGA debug access.
- Arbitrates between NREQ command requesters in round-robin order and executes one command at a time on the shared TCK/TMS/TDI/TDO pins.
- Supported commands: TAP reset, TMS sequence, scan, and scan with TMS flip on the last bit.
- Returns captured TDO bits to the requester that issued the command.

Parameters:
NREQ, 2, number of requesters (1..8)
TCK_DIV, 4, clk cycles per TCK half period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  when low, no new command is granted
req_valid  in  NREQ  per-requester command valid
req_ready  out  NREQ  one-hot grant; combinational, high only in IDLE
req_cmd  in  3*NREQ  command code: 0 RESET, 1 TMS_SEQ, 2 SCAN, 3 SCAN_FLIP_TMS, 4-7 invalid
req_nbits  in  6*NREQ  bit count 1..32; value 0 means 32; ignored for RESET
req_data  in  32*NREQ  TMS bits (TMS_SEQ) or TDI bits (SCAN*), sent LSB first
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accept
rsp_id  out  3  index of the requester that issued the command
rsp_data  out  32  captured TDO bits, LSB = first bit; unused upper bits 0
rsp_err  out  1  invalid command code
busy  out  1  high when state is not IDLE
tck  out  1  JTAG clock
tms  out  1  JTAG mode select
tdi  out  1  JTAG data in
tdo  in  1  JTAG data out

Behaviour:
- Interface: one clock domain on clk. Reset is asynchronous and active-low on rst_n; all flops clear immediately on rst_n low.
- Reset values: tck=0, tms=0, tdi=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_id=0, busy=0, req_ready=0, round-robin pointer=0.
- States:
  - IDLE: entered from reset.
  - SHIFT_LO / SHIFT_HI: one TCK half period each.
  - RESP: rsp_valid=1 until rsp_ready.
- Arbitration in IDLE, when enable=1:
  - Grant the first requester with req_valid=1, searching from the pointer upward with wrap.
  - req_ready for the winner is high in that cycle; accept edge = that clk edge.
  - Pointer moves to winner+1 mod NREQ.
  - No grant while in RESP or any other non-IDLE state.
- On accept, latch cmd, nbits, data and id.
  - Invalid cmd: no TCK activity. Go to RESP at the next edge with rsp_err=1 and rsp_data=0.
  - Valid cmd: enter SHIFT_LO with bit index 0.
- Internal sequence:
  - RESET: 6 bits, TMS pattern 1,1,1,1,1,0 (ends in Run-Test/Idle). TDI=0.
  - TMS_SEQ: tms=data[i] for each bit. TDI=0.
  - SCAN: tdi=data[i], tms=0.
  - SCAN_FLIP_TMS: as SCAN, but tms=1 on the last bit only.
- Bit timing:
  - At entry to SHIFT_LO, tms/tdi are set for the bit and tck=0.
  - After TCK_DIV cycles: tck rises, tdo is sampled into capture[i] on that same clk edge, state goes to SHIFT_HI.
  - After TCK_DIV cycles: tck falls. If i<N-1, increment i and enter SHIFT_LO for the next bit. Else enter RESP.
  - Bit period = 2*TCK_DIV clk cycles.
- Latency: rsp_valid rises exactly 2*TCK_DIV*N cycles after the accept edge (N = 6 for RESET). Invalid cmd: 1 cycle.
- On entering RESP: tms=0, tdi=0, tck=0; rsp_data=capture (bits >= N forced 0), rsp_err=0. TMS_SEQ and RESET also return their capture.
- RESP → IDLE on rsp_valid && rsp_ready. A new grant is possible in the following cycle, not the same one.
- enable falling mid-command: the current command completes and responds; only new grants are blocked.
- req_valid dropping after accept has no effect on the command. A requester whose req_valid drops before grant is simply skipped.
- rst_n asserted mid-command: tck, tms and tdi go to 0 immediately; the command is discarded and no response is issued.
- Upper rsp_id bits are 0 when NREQ<8.

Test Plan:
- RESET from req0, TCK_DIV=4 → 6 tck pulses with tms=1,1,1,1,1,0. rsp_valid exactly 48 cycles after accept, rsp_id=0, rsp_err=0.
- SCAN req1, nbits=8, data=0xA5, tdo looped to tdi → tdi=1,0,1,0,0,1,0,1 on rising edges, tms=0 throughout. rsp_data=0x000000A5, rsp_id=1.
- SCAN_FLIP_TMS, nbits=0 (32), data=0xDEADBEEF, tdo tied 1 → tms=1 only during bit 31. rsp_data=0xFFFFFFFF, 64*TCK_DIV-cycle latency.
- Both requesters held valid, three commands each → grants alternate 0,1,0,1,0,1. Responses carry matching rsp_id; no grant while rsp_ready is held low for 10 cycles.
- req_cmd=5 → no tck edges, rsp_valid next cycle with rsp_err=1, rsp_data=0. enable=0 with req_valid=1 → req_ready stays 0.
- rst_n low during bit 3 of an 8-bit scan → tck/tms/tdi=0 immediately, no rsp_valid. After release, state is IDLE and the next command executes normally.
